// File: rtl/fp_pkg.sv
// Shared FP32 field constants, rounding modes and accumulator states.
// Imported by the accumulator control and its adder.
package fp_pkg;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MAN_W    = 23;

  localparam logic [7:0]  EXP_MAX     = 8'hFF;
  localparam logic [31:0] FP_POS_ZERO = 32'h0;

  localparam logic [1:0] RM_RNE = 2'd0;
  localparam logic [1:0] RM_RTZ = 2'd1;
  localparam logic [1:0] RM_RUP = 2'd2;
  localparam logic [1:0] RM_RDN = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } acc_state_t;

endpackage

// File: rtl/FpAdder.sv
// Combinational FP32 adder; no denormal support (zero has a hidden 1),
// overflow saturates to infinity, underflow flushes to zero.
module FpAdder
  import fp_pkg::*;
#(
  parameter int D_LEN = 32
) (
  input  logic [D_LEN-1:0] a,
  input  logic [D_LEN-1:0] b,
  input  logic [1:0]       round_mode,
  output logic [D_LEN-1:0] result
);

  logic              a_big;
  logic [31:0]       big;
  logic [30:0]       sml;
  logic              sign;
  logic              sub;
  logic [7:0]        diff;
  logic [50:0]       sh;
  logic              stk;
  logic [27:0]       m_big;
  logic [27:0]       m_sml;
  logic [27:0]       sum;
  logic [26:0]       norm;
  logic [4:0]        p;
  logic [4:0]        shamt;
  logic signed [9:0] e;
  logic              g;
  logic              r;
  logic              inc;
  logic              carry;
  logic [23:0]       rnd;
  logic [22:0]       frac;

  always_comb begin
    a_big  = a[EXP_MSB:0] >= b[EXP_MSB:0];
    big    = a_big ? a : b;
    sml    = a_big ? b[EXP_MSB:0] : a[EXP_MSB:0];
    sign   = big[SIGN_BIT];
    sub    = a[SIGN_BIT] ^ b[SIGN_BIT];
    diff   = big[EXP_MSB:EXP_LSB] - sml[EXP_MSB:EXP_LSB];
    sh     = {1'b1, sml[MAN_W-1:0], 27'b0} >> diff;
    stk    = (diff > 8'd50) | (|sh[24:0]);
    m_big  = {1'b0, 1'b1, big[MAN_W-1:0], 3'b000};
    m_sml  = {1'b0, sh[50:25], stk};
    sum    = sub ? m_big - m_sml : m_big + m_sml;
    e      = {2'b00, big[EXP_MSB:EXP_LSB]};
    norm   = '0;
    p      = '0;
    shamt  = '0;
    if (sum[27]) begin
      norm = {sum[27:2], |sum[1:0]};
      e    = e + 10'sd1;
    end else begin
      for (int i = 0; i < 27; i++)
        if (sum[i]) p = 5'(i);
      shamt = 5'd26 - p;
      norm  = sum[26:0] << shamt;
      e     = e - $signed({5'b0, shamt});
    end
    g   = norm[2];
    r   = |norm[1:0];
    inc = 1'b0;
    unique case (1'b1)
      round_mode == RM_RNE: inc = g & (r | norm[3]);
      round_mode == RM_RTZ: inc = 1'b0;
      round_mode == RM_RUP: inc = ~sign & (g | r);
      round_mode == RM_RDN: inc = sign & (g | r);
      default:              inc = 1'b0;
    endcase
    {carry, rnd} = {1'b0, norm[26:3]} + 25'(inc);
    frac = carry ? rnd[23:1] : rnd[22:0];
    if (carry) e = e + 10'sd1;
    if (sum == '0 || e < 10'sd1)
      result = '0;
    else if (e > 10'sd254)
      result = {sign, EXP_MAX, 23'b0};
    else
      result = {sign, e[7:0], frac};
  end

endmodule

// File: rtl/fp_accumulator.sv
// Streams FP32 elements into a running left-fold sum and presents
// the finished scalar on a valid/ready output.
module fp_accumulator
  import fp_pkg::*;
#(
  parameter int D_LEN = 32,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] vec_len,
  input  logic [1:0]       round_mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [D_LEN-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [D_LEN-1:0] out_data,
  output logic             out_ovf,
  output logic             busy
);

  acc_state_t       state;
  acc_state_t       state_n;
  logic [D_LEN-1:0] acc;
  logic [D_LEN-1:0] sum;
  logic [D_LEN-1:0] acc_n;
  logic [LEN_W-1:0] remaining;
  logic             first;
  logic             ovf;
  logic [1:0]       rm_q;
  logic             beat;

  FpAdder #(.D_LEN(D_LEN)) u_add (
    .a          (acc),
    .b          (in_data),
    .round_mode (rm_q),
    .result     (sum)
  );

  assign beat  = in_valid & in_ready;
  // zero would be read by the adder as 1.0 * 2^-127, so seed directly
  assign acc_n = first ? in_data : sum;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start)
          state_n = (vec_len == '0) ? DONE : ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (beat && remaining == LEN_W'(1))
          state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= FP_POS_ZERO;
      remaining <= '0;
      first     <= 1'b0;
      ovf       <= 1'b0;
      rm_q      <= RM_RNE;
    end else if (state == IDLE && start) begin
      acc       <= FP_POS_ZERO;
      remaining <= vec_len;
      first     <= 1'b1;
      ovf       <= 1'b0;
      rm_q      <= round_mode;
    end else if (beat) begin
      acc       <= acc_n;
      remaining <= remaining - LEN_W'(1);
      first     <= 1'b0;
      if (acc_n[EXP_MSB:EXP_LSB] == EXP_MAX)
        ovf <= 1'b1;
    end
  end

  assign out_data = out_valid ? acc : FP_POS_ZERO;
  assign out_ovf  = out_valid & ovf;

endmodule

// File: tb/tb_fp_accumulator.sv
// Scoreboard bench for fp_accumulator: expected sums are queued at
// stimulus time and popped when out_valid appears.
module tb_fp_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] vec_len;
  logic [1:0]  round_mode;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_ovf;
  logic        busy;

  always #5 clk = ~clk;

  fp_accumulator #(.D_LEN(32), .LEN_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .vec_len    (vec_len),
    .round_mode (round_mode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ovf    (out_ovf),
    .busy       (busy)
  );

  typedef struct {
    logic [31:0] data;
    logic [31:0] mask;
    logic        ovf;
  } exp_t;

  exp_t        sb[$];
  int          passed = 0;
  int          total  = 0;
  logic [31:0] vec[4];
  int          rdy_low;

  task automatic push_exp(input logic [31:0] d, input logic [31:0] m,
                          input logic o);
    exp_t e;
    e.data = d;
    e.mask = m;
    e.ovf  = o;
    sb.push_back(e);
  endtask

  task automatic drive_vec(input int n, input int gap);
    @(negedge clk);
    start      = 1'b1;
    vec_len    = 16'(n);
    round_mode = 2'd0;
    @(negedge clk);
    start   = 1'b0;
    rdy_low = 0;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < gap; k++) begin
        in_valid = 1'b0;
        if (in_ready !== 1'b1) rdy_low++;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = vec[i];
      if (in_ready !== 1'b1) rdy_low++;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    start      = 1'b0;
    vec_len    = '0;
    round_mode = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid);
    else passed++;
    total++;
    if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b want 0", in_ready);
    else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy);
    else passed++;
    total++;
    if (out_data !== 32'h0) $display("FAIL rst_out_data got %h want 0", out_data);
    else passed++;
    total++;
    if (out_ovf !== 1'b0) $display("FAIL rst_out_ovf got %b want 0", out_ovf);
    else passed++;
  endtask

  task automatic test_sum_basic();
    exp_t e;
    int   lat;
    vec[0] = 32'h3F800000;
    vec[1] = 32'h40000000;
    vec[2] = 32'h40400000;
    push_exp(32'h40C00000, 32'hFFFFFFFF, 1'b0);
    drive_vec(3, 0);
    wait_out(lat);
    e = sb.pop_front();
    total++;
    if (lat !== 0) $display("FAIL basic_latency got %0d want 0", lat);
    else passed++;
    total++;
    if ((out_data & e.mask) !== e.data)
      $display("FAIL basic_data got %h want %h", out_data, e.data);
    else passed++;
    total++;
    if (out_ovf !== e.ovf) $display("FAIL basic_ovf got %b want %b", out_ovf, e.ovf);
    else passed++;
    release_out();
    total++;
    if (busy !== 1'b0) $display("FAIL basic_busy_after_ack got %b want 0", busy);
    else passed++;
  endtask

  task automatic test_zero_len();
    exp_t e;
    int   rdy_seen;
    push_exp(32'h0, 32'hFFFFFFFF, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'h3F800000;
    @(negedge clk);
    start   = 1'b1;
    vec_len = 16'd0;
    @(negedge clk);
    start = 1'b0;
    e = sb.pop_front();
    total++;
    if (out_valid !== 1'b1) $display("FAIL zero_valid got %b want 1", out_valid);
    else passed++;
    total++;
    if ((out_data & e.mask) !== e.data)
      $display("FAIL zero_data got %h want %h", out_data, e.data);
    else passed++;
    rdy_seen = (in_ready === 1'b1) ? 1 : 0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    if (in_ready === 1'b1) rdy_seen++;
    @(negedge clk);
    if (in_ready === 1'b1) rdy_seen++;
    in_valid = 1'b0;
    total++;
    if (rdy_seen !== 0) $display("FAIL zero_in_ready got %0d cycles want 0", rdy_seen);
    else passed++;
  endtask

  task automatic test_single();
    exp_t e;
    int   lat;
    vec[0] = 32'h3DCCCCCD;
    push_exp(32'h3DCCCCCD, 32'hFFFFFFFF, 1'b0);
    drive_vec(1, 0);
    wait_out(lat);
    e = sb.pop_front();
    total++;
    if (lat !== 0) $display("FAIL single_latency got %0d want 0", lat);
    else passed++;
    total++;
    if ((out_data & e.mask) !== e.data)
      $display("FAIL single_data got %h want %h", out_data, e.data);
    else passed++;
    release_out();
  endtask

  task automatic test_cancel(input int gap);
    exp_t e;
    int   lat;
    vec[0] = 32'h40A00000;
    vec[1] = 32'hC0A00000;
    push_exp(32'h0, 32'h7FFFFFFF, 1'b0);
    drive_vec(2, gap);
    wait_out(lat);
    e = sb.pop_front();
    total++;
    if (lat !== 0) $display("FAIL cancel_latency gap=%0d got %0d want 0", gap, lat);
    else passed++;
    total++;
    if ((out_data & e.mask) !== e.data)
      $display("FAIL cancel_data gap=%0d got %h want %h", gap, out_data, e.data);
    else passed++;
    total++;
    if (rdy_low !== 0)
      $display("FAIL cancel_in_ready gap=%0d got %0d low cycles want 0", gap, rdy_low);
    else passed++;
    release_out();
  endtask

  task automatic test_overflow_hold();
    exp_t e;
    int   lat;
    int   bad;
    vec[0] = 32'h7F7FFFFF;
    vec[1] = 32'h7F7FFFFF;
    push_exp(32'h7F800000, 32'h7F800000, 1'b1);
    drive_vec(2, 0);
    wait_out(lat);
    e = sb.pop_front();
    total++;
    if ((out_data & e.mask) !== e.data)
      $display("FAIL ovf_exp got %h want %h", out_data, e.data);
    else passed++;
    total++;
    if (out_ovf !== e.ovf) $display("FAIL ovf_flag got %b want %b", out_ovf, e.ovf);
    else passed++;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      start   = (c == 2);
      vec_len = 16'd3;
      @(negedge clk);
      if (out_valid !== 1'b1 || (out_data & e.mask) !== e.data ||
          out_ovf !== e.ovf || busy !== 1'b1)
        bad++;
    end
    start = 1'b0;
    total++;
    if (bad !== 0) $display("FAIL ovf_hold got %0d unstable cycles want 0", bad);
    else passed++;
    release_out();
    total++;
    if (busy !== 1'b0) $display("FAIL ovf_release_busy got %b want 0", busy);
    else passed++;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   lat;
    @(negedge clk);
    start   = 1'b1;
    vec_len = 16'd4;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h40400000;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    total++;
    if ({out_valid, in_ready, busy, out_ovf} !== 4'b0)
      $display("FAIL midrst_ctrl got %b want 0000", {out_valid, in_ready, busy, out_ovf});
    else passed++;
    total++;
    if (out_data !== 32'h0) $display("FAIL midrst_data got %h want 0", out_data);
    else passed++;
    rst_n  = 1'b1;
    vec[0] = 32'h40000000;
    push_exp(32'h40000000, 32'hFFFFFFFF, 1'b0);
    drive_vec(1, 0);
    wait_out(lat);
    e = sb.pop_front();
    total++;
    if ((out_data & e.mask) !== e.data || lat !== 0)
      $display("FAIL midrst_fresh got %h lat %0d want %h lat 0", out_data, lat, e.data);
    else passed++;
    release_out();
  endtask

  initial begin
    test_reset();
    test_sum_basic();
    test_zero_len();
    test_single();
    test_cancel(0);
    test_cancel(3);
    test_overflow_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
